// File: rtl/vscale_hasti_master_port_if.sv
// rtl/vscale_hasti_master_port_if.sv - request/response stream and HASTI bus signals of the master port
interface vscale_hasti_master_port_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [2:0]  req_size;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;

    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic        hmastlock;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    modport master (
        input  req_valid, req_addr, req_write, req_size, req_wdata,
        input  hrdata, hready, hresp,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata
    );

    modport slave (
        output req_valid, req_addr, req_write, req_size, req_wdata,
        output hrdata, hready, hresp,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata
    );
endinterface

// File: rtl/vscale_hasti_master_port.sv
// rtl/vscale_hasti_master_port.sv - HASTI master turning a request stream into pipelined single transfers
// Optional VSCALE_HASTI_MASTER_ALIGN_CHECK_EN: misaligned requests skip the bus and complete with an error.
module vscale_hasti_master_port #(
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input logic                        hclk,
    input logic                        hresetn,
    vscale_hasti_master_port_if.master bus
);
    localparam logic [1:0] HTRANS_IDLE        = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ      = 2'b10;
    localparam logic [2:0] HBURST_SINGLE      = 3'b000;
    localparam logic [2:0] HASTI_SIZE_BYTE     = 3'd0;
    localparam logic [2:0] HASTI_SIZE_HALFWORD = 3'd1;
    localparam logic [2:0] HASTI_SIZE_WORD     = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_CANCEL = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Address-phase request (held until the slave takes it)
    logic [31:0] a_addr;
    logic        a_write;
    logic [2:0]  a_size;
    logic [31:0] a_wdata;
    logic        a_misaligned;

    // Data-phase slot
    logic        d_valid;
    logic        d_write;
    logic [2:0]  d_size;
    logic [1:0]  d_off;
    logic [31:0] d_wdata;
    logic        d_misaligned;

    logic        accept;
    logic        load_a;
    logic        move_d;
    logic        req_misaligned;
    logic [31:0] rdata_shifted;
    logic [31:0] rdata_masked;

    assign bus.req_ready = bus.hready && (state != ST_CANCEL);
    assign accept        = bus.req_valid && bus.req_ready;

`ifdef VSCALE_HASTI_MASTER_ALIGN_CHECK_EN
    assign req_misaligned = ((bus.req_size == HASTI_SIZE_HALFWORD) && bus.req_addr[0]) ||
                            ((bus.req_size == HASTI_SIZE_WORD) && (bus.req_addr[1:0] != 2'b00));
`else
    assign req_misaligned = 1'b0;
`endif

    always_comb begin
        state_next = state;
        load_a     = 1'b0;
        move_d     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    load_a     = 1'b1;
                    state_next = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (bus.hready) begin
                    move_d = 1'b1;
                    if (accept) begin
                        load_a = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else if (bus.hresp) begin
                    // First ERROR cycle: the slave cancels our address phase, so replay it later
                    state_next = ST_CANCEL;
                end
            end
            ST_CANCEL: begin
                if (bus.hready) begin
                    state_next = ST_ACTIVE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            a_addr       <= 32'h0;
            a_write      <= 1'b0;
            a_size       <= 3'd0;
            a_wdata      <= 32'h0;
            a_misaligned <= 1'b0;
        end else if (load_a) begin
            a_addr       <= bus.req_addr;
            a_write      <= bus.req_write;
            a_size       <= bus.req_size;
            a_wdata      <= bus.req_wdata;
            a_misaligned <= req_misaligned;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            d_valid      <= 1'b0;
            d_write      <= 1'b0;
            d_size       <= 3'd0;
            d_off        <= 2'd0;
            d_wdata      <= 32'h0;
            d_misaligned <= 1'b0;
        end else if (bus.hready) begin
            d_valid <= move_d;
            if (move_d) begin
                d_write      <= a_write;
                d_size       <= a_size;
                d_off        <= a_addr[1:0];
                d_wdata      <= a_wdata;
                d_misaligned <= a_misaligned;
            end
        end
    end

    assign bus.haddr     = a_addr;
    assign bus.hwrite    = a_write;
    assign bus.hsize     = a_size;
    assign bus.hburst    = HBURST_SINGLE;
    assign bus.hmastlock = 1'b0;
    assign bus.hprot     = HPROT_VAL;
    assign bus.htrans    = ((state == ST_ACTIVE) && !a_misaligned) ? HTRANS_NONSEQ : HTRANS_IDLE;

    // Write data is replicated across all byte lanes so the slave can pick its lane
    always_comb begin
        bus.hwdata = 32'h0;
        if (d_valid && d_write && !d_misaligned) begin
            case (d_size)
                HASTI_SIZE_BYTE:     bus.hwdata = {4{d_wdata[7:0]}};
                HASTI_SIZE_HALFWORD: bus.hwdata = {2{d_wdata[15:0]}};
                default:             bus.hwdata = d_wdata;
            endcase
        end
    end

    assign rdata_shifted = bus.hrdata >> {d_off, 3'b000};

    always_comb begin
        rdata_masked = rdata_shifted;
        case (d_size)
            HASTI_SIZE_BYTE:     rdata_masked = {24'h0, rdata_shifted[7:0]};
            HASTI_SIZE_HALFWORD: rdata_masked = {16'h0, rdata_shifted[15:0]};
            default:             rdata_masked = rdata_shifted;
        endcase
    end

    assign bus.resp_valid = d_valid && bus.hready;
    assign bus.resp_error = bus.resp_valid && (bus.hresp || d_misaligned);
    assign bus.resp_rdata = (bus.resp_valid && !d_write && !d_misaligned) ? rdata_masked : 32'h0;
endmodule

// File: tb/tb_vscale_hasti_master_port.sv
// tb/tb_vscale_hasti_master_port.sv - self-checking bench with SRAM slave model and response scoreboard
`timescale 1ns/1ps
module tb_vscale_hasti_master_port;
    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [2:0] SZ_B     = 3'd0;
    localparam logic [2:0] SZ_H     = 3'd1;
    localparam logic [2:0] SZ_W     = 3'd2;
    localparam int         TR_LEN   = 4096;
    localparam int         NVEC     = 16;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_hwdata;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    logic hclk = 1'b0;
    logic hresetn;
    int   cyc = 0;
    int   total;
    int   bad;

    always #5 hclk = ~hclk;
    always @(posedge hclk) cyc <= cyc + 1;

    vscale_hasti_master_port_if bus();

    vscale_hasti_master_port dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus)
    );

    // SRAM slave model with per-address wait-state and ERROR injection
    logic [31:0] mem [0:63];
    logic        s_valid, s_write, s_err, s_errc;
    logic [31:0] s_addr;
    logic [2:0]  s_size;
    int          s_wait;
    logic [31:0] wait_addr;
    int          wait_n;
    logic [31:0] err_addr;

    function automatic logic lane_en(input logic [1:0] a, input logic [2:0] sz, input int b);
        if (sz == SZ_B) return b == int'(a);
        if (sz == SZ_H) return (b / 2) == int'(a[1]);
        return 1'b1;
    endfunction

    always @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            s_valid <= 1'b0;
            s_write <= 1'b0;
            s_err   <= 1'b0;
            s_errc  <= 1'b0;
            s_addr  <= 32'h0;
            s_size  <= 3'd0;
            s_wait  <= 0;
        end else if (bus.hready) begin
            if (s_valid && s_write && !s_err) begin
                for (int b = 0; b < 4; b++) begin
                    if (lane_en(s_addr[1:0], s_size, b)) mem[s_addr[7:2]][8*b +: 8] <= bus.hwdata[8*b +: 8];
                end
            end
            s_valid <= (bus.htrans == T_NONSEQ);
            s_addr  <= bus.haddr;
            s_write <= bus.hwrite;
            s_size  <= bus.hsize;
            s_err   <= (bus.htrans == T_NONSEQ) && (bus.haddr == err_addr);
            s_errc  <= 1'b0;
            s_wait  <= ((bus.htrans == T_NONSEQ) && (bus.haddr == wait_addr)) ? wait_n : 0;
        end else begin
            if (s_wait > 0) s_wait <= s_wait - 1;
            if (s_err) s_errc <= 1'b1;
        end
    end

    always_comb begin
        bus.hready = 1'b1;
        bus.hresp  = 1'b0;
        bus.hrdata = mem[s_addr[7:2]];
        if (s_valid && s_err) begin
            bus.hresp  = 1'b1;
            bus.hready = s_errc;
        end else if (s_valid && (s_wait != 0)) begin
            bus.hready = 1'b0;
        end
    end

    logic [1:0]  tr_trans [TR_LEN];
    logic [31:0] tr_addr  [TR_LEN];
    logic        tr_rdy   [TR_LEN];
    logic [31:0] tr_wdata [TR_LEN];
    exp_t        sb [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                                input logic [31:0] wdata, input logic [31:0] rdata, input logic err,
                                input int lat, input logic [31:0] hw);
        vec_t v;
        v.wr = wr; v.addr = addr; v.size = size; v.wdata = wdata;
        v.exp_rdata = rdata; v.exp_err = err; v.exp_lat = lat; v.exp_hwdata = hw;
        return v;
    endfunction

    task automatic send(input vec_t v, output int acc);
        int   n;
        exp_t e;
        n = 0;
        @(negedge hclk);
        bus.req_valid = 1'b1;
        bus.req_addr  = v.addr;
        bus.req_write = v.wr;
        bus.req_size  = v.size;
        bus.req_wdata = v.wdata;
        while (!bus.req_ready && n < 50) begin
            @(negedge hclk);
            n++;
        end
        if (n >= 50) begin
            check("req_ready_timeout", 32'(bus.req_ready), 32'd1);
            bus.req_valid = 1'b0;
            acc = 0;
        end else begin
            acc     = cyc;
            e.rdata = v.exp_rdata;
            e.err   = v.exp_err;
            e.lat   = v.exp_lat;
            e.acc   = cyc;
            sb.push_back(e);
            @(posedge hclk);
        end
    endtask

    task automatic idle();
        @(negedge hclk);
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge hclk);
            n++;
        end
        repeat (2) @(negedge hclk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
    endtask

    vec_t        tbl [NVEC];
    int          acc [NVEC];
    int          a1, a2, a3, aw, ar, am, ax;
    logic        exp_mis_err;
    logic [31:0] exp_mis_rdata;
    logic [1:0]  exp_mis_trans;

    initial begin
        total = 0;
        bad   = 0;
        hresetn       = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_write = 1'b0;
        bus.req_size  = 3'd0;
        bus.req_wdata = 32'h0;
        wait_addr     = '1;
        wait_n        = 0;
        err_addr      = '1;

        tbl[0]  = mk(1, 32'h40, SZ_W, 32'h12345678, 32'h0,        0, 2, 32'h12345678);
        tbl[1]  = mk(0, 32'h40, SZ_W, 32'h0,        32'h12345678, 0, 2, 32'h0);
        tbl[2]  = mk(1, 32'h40, SZ_W, 32'hAABBCCDD, 32'h0,        0, 2, 32'hAABBCCDD);
        tbl[3]  = mk(0, 32'h43, SZ_B, 32'h0,        32'h000000AA, 0, 2, 32'h0);
        tbl[4]  = mk(0, 32'h42, SZ_H, 32'h0,        32'h0000AABB, 0, 2, 32'h0);
        tbl[5]  = mk(1, 32'h41, SZ_B, 32'h0000005A, 32'h0,        0, 2, 32'h5A5A5A5A);
        tbl[6]  = mk(0, 32'h40, SZ_W, 32'h0,        32'hAABB5ADD, 0, 2, 32'h0);
        tbl[7]  = mk(0, 32'h41, SZ_B, 32'h0,        32'h0000005A, 0, 2, 32'h0);
        tbl[8]  = mk(1, 32'h00, SZ_W, 32'h11111111, 32'h0,        0, 2, 32'h11111111);
        tbl[9]  = mk(1, 32'h04, SZ_W, 32'h22222222, 32'h0,        0, 2, 32'h22222222);
        tbl[10] = mk(1, 32'h08, SZ_W, 32'h33333333, 32'h0,        0, 2, 32'h33333333);
        tbl[11] = mk(1, 32'h0C, SZ_H, 32'h00004444, 32'h0,        0, 2, 32'h44444444);
        tbl[12] = mk(0, 32'h00, SZ_W, 32'h0,        32'h11111111, 0, 2, 32'h0);
        tbl[13] = mk(0, 32'h04, SZ_W, 32'h0,        32'h22222222, 0, 2, 32'h0);
        tbl[14] = mk(0, 32'h08, SZ_W, 32'h0,        32'h33333333, 0, 2, 32'h0);
        tbl[15] = mk(0, 32'h0C, SZ_H, 32'h0,        32'h00004444, 0, 2, 32'h0);

        fork
            forever begin
                exp_t e;
                @(negedge hclk);
                if (cyc < TR_LEN) begin
                    tr_trans[cyc] = bus.htrans;
                    tr_addr[cyc]  = bus.haddr;
                    tr_rdy[cyc]   = bus.req_ready;
                    tr_wdata[cyc] = bus.hwdata;
                end
                if (bus.resp_valid) begin
                    if (sb.size() == 0) begin
                        check("resp_unexpected", 32'(bus.resp_valid), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("resp_rdata", bus.resp_rdata, e.rdata);
                        check("resp_error", 32'(bus.resp_error), 32'(e.err));
                        check("resp_latency", 32'(cyc - e.acc), 32'(e.lat));
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(negedge hclk);
        check("rst_htrans", 32'(bus.htrans), 32'(T_IDLE));
        check("rst_haddr", bus.haddr, 32'h0);
        check("rst_hwrite", 32'(bus.hwrite), 32'h0);
        check("rst_hsize", 32'(bus.hsize), 32'h0);
        check("rst_hwdata", bus.hwdata, 32'h0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        check("rst_resp_error", 32'(bus.resp_error), 32'h0);
        check("rst_resp_rdata", bus.resp_rdata, 32'h0);
        check("hburst", 32'(bus.hburst), 32'h0);
        check("hmastlock", 32'(bus.hmastlock), 32'h0);
        check("hprot", 32'(bus.hprot), 32'h3);
        hresetn = 1'b1;
        repeat (2) @(negedge hclk);

        // Table vectors, back to back
        for (int i = 0; i < NVEC; i++) send(tbl[i], acc[i]);
        idle();
        drain();
        for (int i = 0; i < NVEC; i++) begin
            check($sformatf("vec%0d_htrans", i), 32'(tr_trans[acc[i] + 1]), 32'(T_NONSEQ));
            check($sformatf("vec%0d_haddr", i), tr_addr[acc[i] + 1], tbl[i].addr);
            check($sformatf("vec%0d_hwdata", i), tr_wdata[acc[i] + 2], tbl[i].exp_hwdata);
        end
        for (int i = 13; i < NVEC; i++) check($sformatf("vec%0d_back_to_back", i), 32'(acc[i] - acc[i-1]), 32'd1);

        // Three wait states on the second of two pipelined reads, third read held in address phase
        wait_addr = 32'h4;
        wait_n    = 3;
        send(mk(0, 32'h0, SZ_W, 0, 32'h11111111, 0, 2, 0), a1);
        send(mk(0, 32'h4, SZ_W, 0, 32'h22222222, 0, 5, 0), a2);
        send(mk(0, 32'h8, SZ_W, 0, 32'h33333333, 0, 5, 0), a3);
        idle();
        drain();
        wait_addr = '1;
        check("wait_accept_gap", 32'(a3 - a2), 32'd1);
        for (int k = 2; k <= 4; k++) begin
            check($sformatf("wait%0d_req_ready", k), 32'(tr_rdy[a2 + k]), 32'd0);
            check($sformatf("wait%0d_htrans", k), 32'(tr_trans[a2 + k]), 32'(T_NONSEQ));
            check($sformatf("wait%0d_haddr", k), tr_addr[a2 + k], 32'h8);
        end
        check("wait_end_req_ready", 32'(tr_rdy[a2 + 5]), 32'd1);

        // Two-cycle ERROR on a write with a read pending in address phase
        err_addr = 32'h20;
        send(mk(1, 32'h20, SZ_W, 32'hDEADBEEF, 32'h0, 1, 3, 32'hDEADBEEF), aw);
        send(mk(0, 32'h08, SZ_W, 0, 32'h33333333, 0, 4, 0), ar);
        idle();
        drain();
        err_addr = '1;
        check("err_accept_gap", 32'(ar - aw), 32'd1);
        check("err_t_htrans", 32'(tr_trans[aw + 2]), 32'(T_NONSEQ));
        check("err_t_req_ready", 32'(tr_rdy[aw + 2]), 32'd0);
        check("err_t1_htrans", 32'(tr_trans[aw + 3]), 32'(T_IDLE));
        check("err_t1_req_ready", 32'(tr_rdy[aw + 3]), 32'd0);
        check("err_replay_htrans", 32'(tr_trans[aw + 4]), 32'(T_NONSEQ));
        check("err_replay_haddr", tr_addr[aw + 4], 32'h8);

        // Misaligned word read between two aligned reads
`ifdef VSCALE_HASTI_MASTER_ALIGN_CHECK_EN
        exp_mis_err   = 1'b1;
        exp_mis_rdata = 32'h0;
        exp_mis_trans = T_IDLE;
`else
        exp_mis_err   = 1'b0;
        exp_mis_rdata = 32'h00002222;
        exp_mis_trans = T_NONSEQ;
`endif
        send(mk(0, 32'h0, SZ_W, 0, 32'h11111111, 0, 2, 0), ax);
        send(mk(0, 32'h6, SZ_W, 0, exp_mis_rdata, exp_mis_err, 2, 0), am);
        send(mk(0, 32'h8, SZ_W, 0, 32'h33333333, 0, 2, 0), ax);
        idle();
        drain();
        check("mis_htrans", 32'(tr_trans[am + 1]), 32'(exp_mis_trans));
        check("mis_haddr", tr_addr[am + 1], 32'h6);

        // Reset during an address phase drops the request
        send(mk(0, 32'h4, SZ_W, 0, 32'h22222222, 0, 2, 0), ax);
        @(negedge hclk);
        bus.req_valid = 1'b0;
        hresetn = 1'b0;
        sb.delete();
        #1;
        check("midrst_htrans", 32'(bus.htrans), 32'(T_IDLE));
        check("midrst_haddr", bus.haddr, 32'h0);
        check("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
        repeat (2) @(negedge hclk);
        hresetn = 1'b1;
        repeat (4) @(negedge hclk);
        send(mk(0, 32'h4, SZ_W, 0, 32'h22222222, 0, 2, 0), ax);
        idle();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vscale_hasti_master_port.md
# vscale_hasti_master_port

- Generic HASTI (AHB-Lite) bus master: turns a simple valid/ready request stream from the core or a DMA engine into pipelined single transfers, and returns one response per request.
- Overlaps address and data phases, handles wait states and two-cycle ERROR responses, and replays a transfer cancelled by an error.
- Drives the HASTI SRAM and other vscale HASTI slaves.

## Interface
- HPROT_VAL, 4'b0011, constant driven on hprot.
- hclk  in  1  clock.
- hresetn  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when both valid and ready are high at a rising edge.
- req_addr  in  32  byte address.
- req_write  in  1  1 = write.
- req_size  in  3  HASTI_SIZE_BYTE, HASTI_SIZE_HALFWORD or HASTI_SIZE_WORD.
- req_wdata  in  32  write data, right-aligned.
- resp_valid  out  1  response strobe, one per accepted request.
- resp_rdata  out  32  read data, right-aligned and zero-extended; 0 for writes.
- resp_error  out  1  transfer got ERROR, or was misaligned (see Configuration).
- haddr  out  32; hwrite  out  1; hsize  out  3; hburst  out  3; hmastlock  out  1; hprot  out  4; htrans  out  2; hwdata  out  32: HASTI master outputs.
- hrdata  in  32; hready  in  1; hresp  in  1: HASTI slave returns.

## Operation
- Fixed outputs: hburst = SINGLE, hmastlock = 0, hprot = HPROT_VAL.
- Only IDLE and NONSEQ are driven on htrans.
- Address-phase FSM:
  - IDLE: htrans=IDLE.
  - ACTIVE: htrans=NONSEQ; haddr/hwrite/hsize come from the held request.
  - CANCEL: htrans=IDLE; the request is retained.
- req_ready = hready && state != CANCEL. This is combinational.
- IDLE: an accepted request is loaded into the address registers; next state ACTIVE.
- ACTIVE, hready=1: the request moves to the data-phase slot. A simultaneous accept reloads the slot and stays ACTIVE; otherwise go to IDLE.
- ACTIVE, hready=0, hresp=0: hold all outputs stable; stay ACTIVE.
- ACTIVE, hready=0, hresp=1 (first ERROR cycle): go to CANCEL. The address-phase request is not lost.
- CANCEL, hready=1: go to ACTIVE, re-issuing the retained request unchanged. CANCEL, hready=0: stay.
- Data-phase slot: dvalid, dwrite, dsize, doff = addr[1:0], dwdata.
  - Loaded only when hready=1.
  - Cleared when hready=1 and no transfer moves in.
- hwdata is driven from the slot:
  - byte: {4{wdata[7:0]}}
  - halfword: {2{wdata[15:0]}}
  - word: wdata
  - 0 when no write is in data phase.
- resp_valid = dvalid && hready. This is combinational.
- resp_error = hresp in that cycle.
- resp_rdata for reads = (hrdata >> 8*doff), masked to 8/16/32 bits.
- Responses are returned strictly in request order.
- Reset, at any time including mid-transfer: all state is cleared and in-flight requests are dropped with no response.
- Reset values:
  - htrans=IDLE; haddr=0; hwrite=0; hsize=0; hwdata=0.
  - resp_valid=0; resp_error=0; resp_rdata=0.
  - FSM=IDLE; dvalid=0.

## Timing
- Request accepted at edge E0 → NONSEQ driven in cycle after E0 (c1) → data phase c2.
- Zero wait states: resp_valid is high in c2, i.e. 2 cycles of latency.
- Throughput is one transfer per cycle back-to-back.
- Each wait cycle (hready=0) adds one cycle to the response. req_ready is low in that cycle.
- ERROR sequence: first ERROR cycle t, second ERROR cycle t+1.
  - resp_valid/resp_error are high at t+1.
  - htrans=IDLE at t+1.
  - The replayed NONSEQ appears at t+2.
- hrdata, hready and hresp are sampled only on hclk rising edges.
- The only combinational input-to-output paths: hready/hrdata/hresp → resp_*, and hready → req_ready.

## Configuration
- Macro VSCALE_HASTI_MASTER_ALIGN_CHECK_EN.
- Defined:
  - A misaligned accept (halfword with addr[0]=1, or word with addr[1:0]≠0) takes its address-phase slot with htrans=IDLE, so no bus transfer occurs.
  - It completes in its data-phase slot with resp_error=1 and resp_rdata=0.
  - Ordering is preserved.
- Undefined: no check; a misaligned request is issued on the bus unchanged, and the slave's behaviour is the result.

## Test plan
- Word write: 0x12345678 to 0x40, then word read of 0x40 against the SRAM model, zero waits → read response 0x12345678; resp_valid exactly 2 cycles after each accept.
- Four back-to-back reads of 0x0, 0x4, 0x8, 0xC → NONSEQ on 4 consecutive cycles; 4 consecutive resp_valid pulses in address order.
- Slave inserts 3 wait states on the 2nd of 2 pipelined reads → haddr/htrans held stable and req_ready=0 during the waits; 2nd response arrives 3 cycles late.
- Memory word 0xAABBCCDD; byte read at 0x43 → 0x000000AA; halfword read at 0x42 → 0x0000AABB; byte write of 0x5A at 0x41 → hwdata=0x5A5A5A5A.
- Two-cycle ERROR on a write with a read to 0x8 pending → resp_error=1; htrans=IDLE for one cycle; read to 0x8 replayed and completes with resp_error=0.
- With the macro defined, word read at 0x6 between two valid reads → no NONSEQ issued for it; middle response has resp_error=1 and rdata 0. Without the macro: NONSEQ issued with haddr=0x6.
